// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-capture FSM states, FIFO sizing and
// helpers for the receive-path register word.
package uart_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_ACK  = 2'd1,
        CAP_WAIT = 2'd2
    } cap_state_e;

    localparam int RX_FIFO_DEPTH = 16;
    localparam int DATA_W        = 8;
    localparam int ENTRY_W       = DATA_W + 1;

    // Register view of a FIFO entry: {23'b0, parity_err, data[7:0]}.
    function automatic logic [31:0] rx_word(input logic [ENTRY_W-1:0] entry);
        return {{(32 - ENTRY_W){1'b0}}, entry};
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one synchronous write port and an asynchronous read port.
// Contents are intentionally not reset; readers gate the output on occupancy.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures completed frames from the receiver with a
// done/ack handshake and presents them first-word fall-through to the host.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_done_i,
    input  logic [7:0]    rx_data_i,
    input  logic          parity_error_i,
    output logic          host_read_data_o,
    input  logic          rd_en_i,
    input  logic          flush_i,
    input  logic [AW:0]   thresh_i,
    output logic [31:0]   rd_data_o,
    output logic [AW:0]   count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          thresh_irq_o,
    output logic          underflow_o
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    cap_state_e         state;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               push;
    logic               pop;
    logic               wr_en;
    logic [ENTRY_W-1:0] head;

    assign empty_o = (count == '0);
    assign full_o  = (count == FULL_COUNT);

    // Full is judged on the registered count, so a pop from full only frees
    // the slot for the next cycle and the receiver keeps holding the frame.
    assign push  = (state == CAP_IDLE) && rx_done_i && !full_o;
    assign pop   = rd_en_i && !empty_o;
    assign wr_en = push && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= CAP_IDLE;
            host_read_data_o <= 1'b0;
        end else begin
            host_read_data_o <= 1'b0;
            case (state)
                CAP_IDLE: begin
                    if (push) begin
                        state            <= CAP_ACK;
                        host_read_data_o <= 1'b1;
                    end
                end
                CAP_ACK:  state <= CAP_WAIT;
                CAP_WAIT: begin
                    if (!rx_done_i) begin
                        state <= CAP_IDLE;
                    end
                end
                default:  state <= CAP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            underflow_o <= 1'b0;
        end else if (flush_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW + 1)'(wr_en) - (AW + 1)'(pop);
            if (rd_en_i && empty_o) begin
                underflow_o <= 1'b1;
            end
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data ({parity_error_i, rx_data_i}),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    assign count_o      = count;
    assign rd_data_o    = empty_o ? 32'h0 : rx_word(head);
    assign thresh_irq_o = (thresh_i != '0) && (count >= thresh_i);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo, checked against a
// queue-based model of the FIFO contents and sticky underflow flag.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_done_i;
    logic [7:0]    rx_data_i;
    logic          parity_error_i;
    logic          host_read_data_o;
    logic          rd_en_i;
    logic          flush_i;
    logic [AW:0]   thresh_i;
    logic [31:0]   rd_data_o;
    logic [AW:0]   count_o;
    logic          empty_o;
    logic          full_o;
    logic          thresh_irq_o;
    logic          underflow_o;

    int passed = 0;
    int total  = 0;

    logic [8:0] q[$];
    bit         m_under;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rx_done_i        (rx_done_i),
        .rx_data_i        (rx_data_i),
        .parity_error_i   (parity_error_i),
        .host_read_data_o (host_read_data_o),
        .rd_en_i          (rd_en_i),
        .flush_i          (flush_i),
        .thresh_i         (thresh_i),
        .rd_data_o        (rd_data_o),
        .count_o          (count_o),
        .empty_o          (empty_o),
        .full_o           (full_o),
        .thresh_irq_o     (thresh_irq_o),
        .underflow_o      (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_head();
        return (q.size() != 0) ? {23'b0, q[0]} : 32'h0;
    endfunction

    task automatic chk_state(input string tag);
        int n;
        n = q.size();
        chk({tag, ":count"}, 32'(count_o), 32'(n));
        chk({tag, ":empty"}, 32'(empty_o), 32'(n == 0));
        chk({tag, ":full"},  32'(full_o),  32'(n == DEPTH));
        chk({tag, ":rdata"}, rd_data_o, exp_head());
        chk({tag, ":under"}, 32'(underflow_o), 32'(m_under));
        chk({tag, ":irq"},   32'(thresh_irq_o), 32'((thresh_i != 0) && (n >= int'(thresh_i))));
    endtask

    // Receiver side: raise done, expect ack next cycle, then release.
    task automatic send_frame(input logic [7:0] d, input logic p);
        rx_data_i      = d;
        parity_error_i = p;
        rx_done_i      = 1'b1;
        tick();
        q.push_back({p, d});
        chk("send:ack", 32'(host_read_data_o), 32'd1);
        rx_done_i = 1'b0;
        chk_state("send");
        tick();
        chk("send:ack_end", 32'(host_read_data_o), 32'd0);
        tick();
    endtask

    task automatic pop_word();
        chk("pop:head", rd_data_o, exp_head());
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        else m_under = 1'b1;
        chk_state("pop");
    endtask

    task automatic push_pop(input logic [7:0] d, input logic p);
        chk("pp:head", rd_data_o, exp_head());
        rx_data_i      = d;
        parity_error_i = p;
        rx_done_i      = 1'b1;
        rd_en_i        = 1'b1;
        tick();
        rd_en_i   = 1'b0;
        rx_done_i = 1'b0;
        void'(q.pop_front());
        q.push_back({p, d});
        chk("pp:ack", 32'(host_read_data_o), 32'd1);
        chk_state("pp");
        tick();
        tick();
    endtask

    initial begin
        rst_n          = 1'b1;
        rx_done_i      = 1'b0;
        rx_data_i      = 8'h00;
        parity_error_i = 1'b0;
        rd_en_i        = 1'b0;
        flush_i        = 1'b0;
        thresh_i       = '0;
        m_under        = 1'b0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk_state("reset");
        chk("reset:ack", 32'(host_read_data_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single frame and parity flag
        send_frame(8'hA5, 1'b0);
        chk("single:rdata", rd_data_o, 32'h0000_00A5);
        chk("single:count", 32'(count_o), 32'd1);
        pop_word();
        send_frame(8'h3C, 1'b1);
        chk("parity:rdata", rd_data_o, 32'h0000_013C);
        pop_word();

        // Fill to full, then back-pressure on the 17th frame
        for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 1'b0);
        chk("fill:full", 32'(full_o), 32'd1);
        rx_data_i      = 8'h10;
        parity_error_i = 1'b0;
        rx_done_i      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full:noack", 32'(host_read_data_o), 32'd0);
            chk("full:count", 32'(count_o), 32'(DEPTH));
        end
        chk("full:head", rd_data_o, 32'h0);
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
        void'(q.pop_front());
        chk("popfull:noack", 32'(host_read_data_o), 32'd0);
        chk("popfull:count", 32'(count_o), 32'(DEPTH - 1));
        tick();
        chk("popfull:ack", 32'(host_read_data_o), 32'd1);
        q.push_back(9'h010);
        rx_done_i = 1'b0;
        chk_state("popfull");
        tick();
        tick();
        for (int i = 1; i <= DEPTH; i++) begin
            chk("fill:order", rd_data_o, 32'(i));
            pop_word();
        end

        // Threshold interrupt
        thresh_i = 5'd4;
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'($urandom));
        chk("thresh:irq_on", 32'(thresh_irq_o), 32'd1);
        pop_word();
        chk("thresh:irq_off", 32'(thresh_irq_o), 32'd0);
        thresh_i = 5'd0;
        #1;
        chk("thresh0:irq", 32'(thresh_irq_o), 32'd0);
        chk_state("thresh0");

        // Simultaneous push/pop at count 5
        send_frame(8'($urandom), 1'($urandom));
        send_frame(8'($urandom), 1'($urandom));
        chk("pp5:count_before", 32'(count_o), 32'd5);
        push_pop(8'($urandom), 1'($urandom));
        chk("pp5:count_after", 32'(count_o), 32'd5);

        // Randomized traffic, wraps pointers many times
        thresh_i = 5'($urandom_range(1, DEPTH));
        for (int i = 0; i < 80; i++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op == 0 && q.size() < DEPTH) send_frame(8'($urandom), 1'($urandom));
            else if (op == 2 && q.size() > 0 && q.size() < DEPTH) push_pop(8'($urandom), 1'($urandom));
            else pop_word();
        end

        // Underflow sticky, then flush
        while (q.size() != 0) pop_word();
        pop_word();
        chk("under:set", 32'(underflow_o), 32'd1);
        tick();
        chk("under:sticky", 32'(underflow_o), 32'd1);
        thresh_i = 5'd4;
        for (int i = 0; i < 7; i++) send_frame(8'($urandom), 1'($urandom));
        chk("flush:count_before", 32'(count_o), 32'd7);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        q.delete();
        m_under = 1'b0;
        chk_state("flush");
        chk("flush:count", 32'(count_o), 32'd0);

        // Write coinciding with flush is dropped but still acked
        rx_data_i = 8'h77;
        rx_done_i = 1'b1;
        flush_i   = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flushwr:ack", 32'(host_read_data_o), 32'd1);
        chk_state("flushwr");
        rx_done_i = 1'b0;
        tick();
        tick();
        chk_state("flushwr2");

        // Reset while in CAP_WAIT with rx_done still high
        pop_word();
        rx_data_i      = 8'h5A;
        parity_error_i = 1'b0;
        rx_done_i      = 1'b1;
        tick();
        chk("rstw:ack", 32'(host_read_data_o), 32'd1);
        q.push_back(9'h05A);
        tick();
        tick();
        chk("rstw:count", 32'(count_o), 32'd1);
        rst_n = 1'b0;
        #1;
        q.delete();
        m_under = 1'b0;
        chk_state("rstw:reset");
        chk("rstw:reset_ack", 32'(host_read_data_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstw:recapture_ack", 32'(host_read_data_o), 32'd1);
        q.push_back(9'h05A);
        rx_done_i = 1'b0;
        chk_state("rstw:recapture");
        tick();
        tick();
        chk_state("rstw:end");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
